modred_arbiter: RTL and testbench

MODRED_ARBITER -- requirements
Module: modred_arbiter

---
 rtl/modred_arbiter_pkg.sv | 26 ++
 rtl/modred_v2.sv | 27 ++
 rtl/modred_arbiter.sv | 119 +++++++++++
 tb/tb_modred_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/modred_arbiter_pkg.sv
// modred_arbiter_pkg: shared helpers for the modular-reduction arbiter.
// Stage records are packed MSB-first as {valid, id, payload}.
`default_nettype none

package modred_arbiter_pkg;

  // Modulus Q = 2^(logq-1) + 1 for a logq-bit residue.
  function automatic int unsigned modq_of(input int unsigned logq);
    return (32'd1 << (logq - 32'd1)) + 32'd1;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 32'd1;
    return r;
  endfunction

  // S1 record: payload = 2*LOGQ operand bits; S2 record: payload = LOGQ residue bits.
  function automatic int unsigned rec_width(input int unsigned idw, input int unsigned payw);
    return 32'd1 + idw + payw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/modred_v2.sv
// modred_v2: combinational a mod (2^(LOGQ-1)+1) for a <= 2^(2*(LOGQ-1)).
`default_nettype none

module modred_v2
  import modred_arbiter_pkg::*;
#(
  parameter int LOGQ = 17
) (
  input  logic [2*LOGQ-1:0] i_a,
  output logic [LOGQ-1:0]   o_r
);

  localparam logic [LOGQ-1:0] c_q = LOGQ'(modq_of(LOGQ));

  logic [LOGQ-2:0] w_lo;
  logic [LOGQ:0]   w_hi;
  logic [LOGQ:0]   w_diff;

  // 2^(LOGQ-1) == -1 (mod Q), so a == lo - hi; one conditional +Q lands in [0, Q-1].
  assign w_lo   = i_a[LOGQ-2:0];
  assign w_hi   = i_a[2*LOGQ-1:LOGQ-1];
  assign w_diff = {2'b00, w_lo} - w_hi;
  assign o_r    = w_diff[LOGQ] ? (w_diff[LOGQ-1:0] + c_q) : w_diff[LOGQ-1:0];

endmodule

`default_nettype wire

// File: rtl/modred_arbiter.sv
// +-----------------------------------------------------------------------+
// | modred_arbiter: NREQ requesters share one 2-stage mod-Q reduction pipe |
// | Macro MODRED_ARBITER_RR_EN selects round-robin (else fixed priority). |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module modred_arbiter
  import modred_arbiter_pkg::*;
#(
  parameter int LOGQ = 17,
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*2*LOGQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   res_valid,
  output logic [LOGQ-1:0]        res_data,
  output logic [IDW-1:0]         res_id,
  input  logic                   res_ready
);

  localparam int c_pw  = 2 * LOGQ;
  localparam int c_s1w = rec_width(IDW, c_pw);
  localparam int c_s2w = rec_width(IDW, LOGQ);

  logic [c_s1w-1:0] r_s1;
  logic [c_s2w-1:0] r_s2;
  logic             r_run;

  logic             w_s1_vld, w_s2_vld;
  logic [IDW-1:0]   w_s1_id;
  logic [c_pw-1:0]  w_s1_pay;
  logic [LOGQ-1:0]  w_red;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_any, w_s2_adv, w_s1_load, w_take;
  logic [c_pw-1:0]  w_ops [NREQ];

  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_ops
    assign w_ops[g] = req_data[g*c_pw +: c_pw];
  end

  assign w_s1_vld = r_s1[c_s1w-1];
  assign w_s1_id  = r_s1[c_s1w-2 -: IDW];
  assign w_s1_pay = r_s1[c_pw-1:0];
  assign w_s2_vld = r_s2[c_s2w-1];

`ifdef MODRED_ARBITER_RR_EN
  logic [IDW-1:0] r_ptr;

  // Descending scan so the requester closest to the pointer is the last writer.
  always_comb begin
    w_gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[IDW'((int'(r_ptr) + k) % NREQ)])
        w_gnt_id = IDW'((int'(r_ptr) + k) % NREQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (w_take)
      r_ptr <= IDW'((int'(w_gnt_id) + 1) % NREQ);
  end
`else
  always_comb begin
    w_gnt_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_gnt_id = IDW'(i);
    end
  end
`endif

  // r_run keeps req_ready low while reset is asserted, even though S1 reads empty.
  assign w_any     = |req_valid;
  assign w_s2_adv  = !w_s2_vld || res_ready;
  assign w_s1_load = !w_s1_vld || w_s2_adv;
  assign w_take    = w_any && w_s1_load && r_run;

  always_comb begin
    req_ready = '0;
    if (w_take) req_ready[w_gnt_id] = 1'b1;
  end

  modred_v2 #(.LOGQ(LOGQ)) u_red (
    .i_a (w_s1_pay),
    .o_r (w_red)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_s1_load)
        r_s1 <= {w_take, w_gnt_id, w_ops[w_gnt_id]};
      if (w_s2_adv) begin
        if (w_s1_vld)
          r_s2 <= {1'b1, w_s1_id, w_red};
        else
          r_s2[c_s2w-1] <= 1'b0;
      end
    end
  end

  assign res_valid = w_s2_vld;
  assign res_id    = r_s2[c_s2w-2 -: IDW];
  assign res_data  = r_s2[LOGQ-1:0];

endmodule

`default_nettype wire

// File: tb/tb_modred_arbiter.sv
// tb_modred_arbiter: directed self-checking bench for modred_arbiter (LOGQ=17, NREQ=4).
`default_nettype none

module tb_modred_arbiter;

  localparam int LOGQ = 17;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int PW   = 2 * LOGQ;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*PW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [LOGQ-1:0]      res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_ready;

  int n_vec = 0;
  int n_bad = 0;

  modred_arbiter #(.LOGQ(LOGQ), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [PW-1:0] a);
    req_data[i*PW +: PW] = a;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b1;
    #3;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_vec++; if (res_data !== 17'd0) begin n_bad++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
    n_vec++; if (res_id !== 2'd0) begin n_bad++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    tick; tick;
    rst = 1'b0;
    tick; tick;
  endtask

  task automatic test_single;
    set_op(2, 34'd196616);
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    tick;
    n_vec++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", res_valid); end
    n_vec++; if (res_data !== 17'd5) begin n_bad++; $display("FAIL single_data: got %0d want 5", res_data); end
    n_vec++; if (res_id !== 2'd2) begin n_bad++; $display("FAIL single_id: got %0d want 2", res_id); end
    tick;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", res_valid); end
  endtask

  task automatic test_back_to_back;
    logic [PW-1:0]   ops [6];
    logic [LOGQ-1:0] exp [6];
    ops = '{34'd4294967296, 34'd65536, 34'd65537, 34'd0, 34'd4294967295, 34'd123456789};
    exp = '{17'd1, 17'd65536, 17'd0, 17'd0, 17'd0, 17'd50618};
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        set_op(0, ops[k]);
        req_valid = 4'b0001;
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 6) begin
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 0001", k, req_ready); end
      end
      tick;
      if (k >= 1) begin
        n_vec++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k - 1, res_valid); end
        n_vec++; if (res_data !== exp[k-1]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k - 1, res_data, exp[k-1]); end
      end
    end
    tick;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", res_valid); end
  endtask

  task automatic test_arbitration;
    logic [IDW-1:0] want;
    rst = 1'b1; #2; rst = 1'b0;
    tick;
    for (int i = 0; i < NREQ; i++) set_op(i, PW'(i));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick;
      if (k >= 1) begin
`ifdef MODRED_ARBITER_RR_EN
        want = IDW'((k - 1) % NREQ);
`else
        want = '0;
`endif
        n_vec++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL arb_valid[%0d]: got %b want 1", k - 1, res_valid); end
        n_vec++; if (res_id !== want) begin n_bad++; $display("FAIL arb_id[%0d]: got %0d want %0d", k - 1, res_id, want); end
        n_vec++; if (res_data !== LOGQ'(want)) begin n_bad++; $display("FAIL arb_data[%0d]: got %0d want %0d", k - 1, res_data, want); end
      end
    end
    req_valid = '0;
    tick; tick;
  endtask

  task automatic test_backpressure;
    res_ready = 1'b0;
    set_op(1, 34'd100);
    req_valid = 4'b0010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_ready0: got %b want 0010", req_ready); end
    tick;
    set_op(1, 34'd101);
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_ready1: got %b want 0010", req_ready); end
    tick;
    set_op(1, 34'd102);
    for (int c = 2; c < 5; c++) begin
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, req_ready); end
      n_vec++; if (res_valid !== 1'b1 || res_data !== 17'd100 || res_id !== 2'd1)
        begin n_bad++; $display("FAIL bp_frozen[%0d]: got v=%b d=%0d id=%0d want v=1 d=100 id=1", c, res_valid, res_data, res_id); end
      tick;
    end
    n_vec++; if (res_valid !== 1'b1 || res_data !== 17'd100) begin n_bad++; $display("FAIL bp_hold_end: got v=%b d=%0d want v=1 d=100", res_valid, res_data); end
    res_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    tick;
    set_op(1, 34'd103);
    n_vec++; if (res_data !== 17'd101 || res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_after1: got v=%b d=%0d want v=1 d=101", res_valid, res_data); end
    tick;
    req_valid = '0;
    n_vec++; if (res_data !== 17'd102 || res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_after2: got v=%b d=%0d want v=1 d=102", res_valid, res_data); end
    tick;
    n_vec++; if (res_data !== 17'd103 || res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_after3: got v=%b d=%0d want v=1 d=103", res_valid, res_data); end
    tick;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup: got %b want 0", res_valid); end
  endtask

  task automatic test_reset_midstream;
    int w;
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, PW'(20 + i));
    req_valid = 4'b1111;
    tick; tick;
    n_vec++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL mid_inflight: got %b want 1", res_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_valid: got %b want 0", res_valid); end
    n_vec++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_async_ready: got %b want 0000", req_ready); end
    tick;
    #2;
    rst = 1'b0;
    res_ready = 1'b1;
    w = 0;
    while (req_ready === 4'b0000 && w < 4) begin
      n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale[%0d]: got %b want 0", w, res_valid); end
      tick;
      w++;
    end
    n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    tick;
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_stale: got %b want 0", res_valid); end
    tick;
    n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 17'd20)
      begin n_bad++; $display("FAIL mid_first_result: got v=%b id=%0d d=%0d want v=1 id=0 d=20", res_valid, res_id, res_data); end
    req_valid = '0;
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_arbitration;
    test_backpressure;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
